// File: rtl/alu_share_arbiter_if.sv
// Requester-side request/response channel for the shared ALU arbiter.
// The master modport is the requester, the slave modport is the arbiter.
interface alu_share_arbiter_if #(
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_rs1;
    logic [31:0]      req_rs2;
    logic [31:0]      req_imm;
    logic [6:0]       req_opcode;
    logic [2:0]       req_funct3;
    logic [6:0]       req_funct7;
    logic [TAG_W-1:0] req_tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output req_valid, req_rs1, req_rs2, req_imm,
        output req_opcode, req_funct3, req_funct7, req_tag,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_tag
    );

    modport slave (
        input  req_valid, req_rs1, req_rs2, req_imm,
        input  req_opcode, req_funct3, req_funct7, req_tag,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_tag
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters,
// with a registered operation stage and a one-entry result buffer each.
module alu_share_arbiter #(
    parameter int TAG_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    alu_share_arbiter_if.slave  s0,
    alu_share_arbiter_if.slave  s1,
    output logic [31:0]         alu_rs1,
    output logic [31:0]         alu_rs2,
    output logic [31:0]         alu_imm,
    output logic [6:0]          alu_opcode,
    output logic [2:0]          alu_funct3,
    output logic [6:0]          alu_funct7,
    input  logic [31:0]         alu_result
);

    typedef struct packed {
        logic [31:0]      rs1;
        logic [31:0]      rs2;
        logic [31:0]      imm;
        logic [6:0]       opcode;
        logic [2:0]       funct3;
        logic [6:0]       funct7;
        logic [TAG_W-1:0] tag;
    } op_t;

    op_t              w_req [2];
    logic [1:0]       w_req_valid;
    logic [1:0]       w_rsp_ready;
    logic [1:0]       w_elig;
    logic [1:0]       w_cand;
    logic [1:0]       w_ready;
    logic [1:0]       w_grant;

    op_t              r_op;
    logic             r_op_valid;
    logic             r_op_owner;
    logic             r_ptr;
    logic [1:0]       r_rsp_valid;
    logic [31:0]      r_rsp_result [2];
    logic [TAG_W-1:0] r_rsp_tag [2];

    always_comb begin
        w_req[0] = '{rs1: s0.req_rs1, rs2: s0.req_rs2,
                     imm: s0.req_imm, opcode: s0.req_opcode,
                     funct3: s0.req_funct3, funct7: s0.req_funct7,
                     tag: s0.req_tag};
        w_req[1] = '{rs1: s1.req_rs1, rs2: s1.req_rs2,
                     imm: s1.req_imm, opcode: s1.req_opcode,
                     funct3: s1.req_funct3, funct7: s1.req_funct7,
                     tag: s1.req_tag};
    end

    assign w_req_valid = {s1.req_valid, s0.req_valid};
    assign w_rsp_ready = {s1.rsp_ready, s0.rsp_ready};

    // A requester is blocked while its own op is in flight or its
    // buffer is full and not draining, so the write-back never collides.
    always_comb begin
        w_elig = '0;
        w_cand = '0;
        for (int i = 0; i < 2; i++) begin
            w_elig[i] = !flush
                && !(r_op_valid && (r_op_owner == 1'(i)))
                && (!r_rsp_valid[i] || w_rsp_ready[i]);
            w_cand[i] = w_req_valid[i] && w_elig[i];
        end
    end

    // Ready never looks at the requester's own valid.
    assign w_ready[0] = rst_n && w_elig[0] && !(w_cand[1] && r_ptr);
    assign w_ready[1] = rst_n && w_elig[1] && !(w_cand[0] && !r_ptr);
    assign w_grant    = w_ready & w_req_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op        <= '0;
            r_op_valid  <= 1'b0;
            r_op_owner  <= 1'b0;
            r_ptr       <= 1'b0;
            r_rsp_valid <= '0;
            for (int i = 0; i < 2; i++) begin
                r_rsp_result[i] <= '0;
                r_rsp_tag[i]    <= '0;
            end
        end else if (flush) begin
            r_op_valid  <= 1'b0;
            r_rsp_valid <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (r_op_valid && (r_op_owner == 1'(i))) begin
                    r_rsp_valid[i]  <= 1'b1;
                    r_rsp_result[i] <= alu_result;
                    r_rsp_tag[i]    <= r_op.tag;
                end else if (r_rsp_valid[i] && w_rsp_ready[i]) begin
                    r_rsp_valid[i] <= 1'b0;
                end
            end
            if (w_grant[0]) begin
                r_op       <= w_req[0];
                r_op_owner <= 1'b0;
                r_op_valid <= 1'b1;
                r_ptr      <= 1'b1;
            end else if (w_grant[1]) begin
                r_op       <= w_req[1];
                r_op_owner <= 1'b1;
                r_op_valid <= 1'b1;
                r_ptr      <= 1'b0;
            end else begin
                r_op_valid <= 1'b0;
            end
        end
    end

    assign s0.req_ready  = w_ready[0];
    assign s1.req_ready  = w_ready[1];
    assign s0.rsp_valid  = r_rsp_valid[0];
    assign s1.rsp_valid  = r_rsp_valid[1];
    assign s0.rsp_result = r_rsp_result[0];
    assign s1.rsp_result = r_rsp_result[1];
    assign s0.rsp_tag    = r_rsp_tag[0];
    assign s1.rsp_tag    = r_rsp_tag[1];

    assign alu_rs1    = r_op.rs1;
    assign alu_rs2    = r_op.rs2;
    assign alu_imm    = r_op.imm;
    assign alu_opcode = r_op.opcode;
    assign alu_funct3 = r_op.funct3;
    assign alu_funct7 = r_op.funct7;

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares one combinational integer ALU instance between two requesters, for example the main execute path and an address or branch-compare helper. Each requester has a valid/ready request port and a valid/ready response port. The arbiter registers the granted operation, drives the shared ALU from that register, and captures the ALU result into a one-entry response buffer for the owning requester. Grants are round-robin, and issue throughput is at most one operation per cycle.

## Interface
Parameters:
- TAG_W, 4, width of the opaque tag carried from request to response

Ports (i = 0, 1 for each requester port group):
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous; drops in-flight and buffered work
- req_valid_i  in  1  requester i presents an operation
- req_ready_i  out  1  request accepted when valid && ready at the edge
- req_rs1_i  in  32  rs1 operand
- req_rs2_i  in  32  rs2 operand
- req_imm_i  in  32  sign-extended I-type immediate
- req_opcode_i  in  7  instruction opcode field
- req_funct3_i  in  3  funct3 field
- req_funct7_i  in  7  funct7 field
- req_tag_i  in  TAG_W  returned unchanged with the result
- rsp_valid_i  out  1  result buffer i holds a result
- rsp_ready_i  in  1  consumer pops the buffer when valid && ready
- rsp_result_i  out  32  ALU result
- rsp_tag_i  out  TAG_W  tag of the result
- alu_rs1, alu_rs2, alu_imm  out  32  operands to the shared ALU
- alu_opcode  out  7, alu_funct3  out  3, alu_funct7  out  7  control fields to the shared ALU
- alu_result  in  32  combinational result from the shared ALU

## Operation
State:
- Operation register: op_valid, op_owner, op_tag, and the six ALU fields.
- Two response buffers: valid, result, tag.
- Round-robin pointer ptr: 1 bit, naming the preferred requester.

Issue:
- Eligibility: eligible_i = !flush && !(op_valid && op_owner==i) && (!rsp_valid_i || rsp_ready_i).
- Grant: requester i is granted when req_valid_i && eligible_i, and the other requester is not both valid and eligible with ptr pointing to it.
- Ready: req_ready_i equals the grant for i. It may depend on the other requester's valid, never on its own.
- Accept: on a grant, load the operation register with requester i's fields, set op_owner=i, op_valid=1, and set ptr = the other requester.
- No grant: with no grant, op_valid becomes 0 and ptr holds.

Execution and write-back:
- ALU drive: alu_* outputs are driven directly from the operation register and hold their last value when op_valid=0.
- Capture: when op_valid, at the next edge alu_result and op_tag are written into response buffer op_owner, setting its valid.
- Release: a buffer's valid clears on a pop that has no simultaneous write.
- Pop and write together: a pop and a write in the same cycle leave valid=1 with the new data.
- Bypass: the write path always lands in a free buffer, because eligibility guaranteed it was free or popping at grant time.

Flush:
- Flush has priority over accept and write-back.
- At the edge: op_valid=0, both rsp_valid=0, ptr unchanged.
- req_ready is low during flush.

## Timing
Reset (rst_n low, asynchronous):
- Outputs: req_ready_i=0 while in reset, rsp_valid_i=0, rsp_result_i=0, rsp_tag_i=0, all alu_* outputs 0.
- Internal: op_valid=0, ptr=0.
- Effect mid-operation: the operation in flight and any buffered results are lost.

Latency:
- Request handshake at edge N.
- Operation register valid, ALU evaluating during cycle N..N+1.
- rsp_valid_i high after edge N+1: one cycle from acceptance to response visible.

Throughput:
- One issue per cycle overall.
- A single requester can issue back-to-back only on alternating cycles, because its own operation in flight blocks it. This bounds each requester to one outstanding result.

Boundary cases:
- Both requesters always valid with free buffers: grants alternate 0,1,0,1 starting from requester 0 after reset.
- Stalled response: if rsp_ready_i is held low with rsp_valid_i=1, requester i is never granted, and the other requester receives every grant (on alternate cycles).

## Test plan
1. Single ADD latency: reset, then requester 0 sends opcode 0110011, funct3 000, funct7 0, rs1=5, rs2=3, tag=2 → req_ready_0=1 same cycle; rsp_valid_0=1 one edge later with result 8, tag 2; alu_funct7=0 during execute.
2. Round-robin contention: both requesters valid every cycle; requester 0 sends SUB (funct7 0x20, rs1=10, rs2=3), requester 1 sends ADDI (opcode 0010011, imm=-1, rs1=0) → grants alternate 0,1,0,1; results 7 and 0xFFFFFFFF respectively; ptr toggles on each grant.
3. Response backpressure: rsp_ready_0=0 after the first result → requester 0 stays at req_ready_0=0 indefinitely and requester 1 gets every grant; releasing rsp_ready_0 for one cycle permits a grant to requester 0 in that same cycle.
4. Simultaneous pop and write: requester 1 result pending, rsp_ready_1=1 and a new requester 1 operation completing in the same cycle → rsp_valid_1 stays 1 and the data changes to the new result with no gap cycle.
5. Flush mid-operation: flush asserted while op_valid=1 and rsp_valid_0=1 → after the edge both rsp_valid=0, no stale result appears, req_ready_i=0 during the flush cycle, ptr preserved.
6. Asynchronous reset mid-operation: drop rst_n between clock edges with an operation in flight → all outputs reach reset values immediately; the first grant after reset goes to requester 0.
